mem_issue_queue: RTL

Buffers memory instructions from the operand collector and issues them in order to `mem_unit`. Issue is throttled by a mem-unit stall input and by a cap on instructions in flight. It also gives backpressure to the operand collector and an idle indication to warp-exit/barrier logic. It sits between the operand-collector MEM port and `mem_unit`, replacing the direct OC→MEM connection.

---
 rtl/gpu_mem_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/mem_issue_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared memory-pipeline types: the instruction payload passed between the
// operand collector, the issue queue and mem_unit.
package gpu_mem_pkg;

  localparam int unsigned NUM_LANES  = 8;
  localparam int unsigned LANE_W     = 32;
  localparam int unsigned WARP_ID_W  = 3;
  localparam int unsigned SCB_ID_W   = 2;
  localparam int unsigned OFFSET_W   = 16;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = NUM_LANES * LANE_W;

  // 549-bit payload; field order is MSB first.
  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  shared_global_bar;  // 1 = shared, 0 = global
    logic [NUM_LANES-1:0]  pam;
    logic [WARP_ID_W-1:0]  warp_id;
    logic [SCB_ID_W-1:0]   scb_id;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [OFFSET_W-1:0]   offset;
    logic [REG_ADDR_W-1:0] reg_addr;
  } mem_instr_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock circular FIFO. Entry storage is not reset; only the
// pointers and occupancy are. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wp, rp;
  logic [CntW-1:0]  cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == CntW'(Depth));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];
  assign count   = cnt;

  // Pointer and occupancy update; pointers wrap naturally since Depth is 2^n.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PtrW'(1);
      if (do_pop)  rp <= rp + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry write; contents of unused slots are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue between the operand collector and mem_unit.
// Issue is gated by mem_unit stall and a cap on instructions in flight.
module mem_issue_queue
  import gpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Instr_valid_OC_MIQ,
  output logic                  ready_MIQ_OC,
  input  logic                  MemRead_OC_MIQ,
  input  logic                  MemWrite_OC_MIQ,
  input  logic                  shared_global_bar_OC_MIQ,
  input  logic [NUM_LANES-1:0]  PAM_OC_MIQ,
  input  logic [WARP_ID_W-1:0]  warp_ID_OC_MIQ,
  input  logic [SCB_ID_W-1:0]   scb_ID_OC_MIQ,
  input  logic [DATA_W-1:0]     rs_data_OC_MIQ,
  input  logic [DATA_W-1:0]     rt_data_OC_MIQ,
  input  logic [OFFSET_W-1:0]   offset_OC_MIQ,
  input  logic [REG_ADDR_W-1:0] reg_addr_OC_MIQ,
  output logic                  Instr_valid_MIQ_MEM,
  output logic                  MemRead_MIQ_MEM,
  output logic                  MemWrite_MIQ_MEM,
  output logic                  shared_global_bar_MIQ_MEM,
  output logic [NUM_LANES-1:0]  PAM_MIQ_MEM,
  output logic [WARP_ID_W-1:0]  warp_ID_MIQ_MEM,
  output logic [SCB_ID_W-1:0]   scb_ID_MIQ_MEM,
  output logic [DATA_W-1:0]     rs_data_MIQ_MEM,
  output logic [DATA_W-1:0]     rt_data_MIQ_MEM,
  output logic [OFFSET_W-1:0]   offset_MIQ_MEM,
  output logic [REG_ADDR_W-1:0] reg_addr_MIQ_MEM,
  input  logic                  stall_MEM_MIQ,
  input  logic                  done_MEM_MIQ,
  output logic [$clog2(DEPTH):0] count_MIQ,
  output logic                  idle_MIQ
);

  localparam int unsigned CntW        = $clog2(DEPTH) + 1;
  localparam logic [3:0]  MaxInflight = 4'(MAX_INFLIGHT);

  mem_instr_t      in_instr, head, out_instr;
  logic            push, pop, full, empty, done_eff;
  logic [CntW-1:0] cnt;
  logic [3:0]      inflight;

  // Gather OC fields into one payload word.
  always_comb begin
    in_instr                   = '0;
    in_instr.mem_read          = MemRead_OC_MIQ;
    in_instr.mem_write         = MemWrite_OC_MIQ;
    in_instr.shared_global_bar = shared_global_bar_OC_MIQ;
    in_instr.pam               = PAM_OC_MIQ;
    in_instr.warp_id           = warp_ID_OC_MIQ;
    in_instr.scb_id            = scb_ID_OC_MIQ;
    in_instr.rs_data           = rs_data_OC_MIQ;
    in_instr.rt_data           = rt_data_OC_MIQ;
    in_instr.offset            = offset_OC_MIQ;
    in_instr.reg_addr          = reg_addr_OC_MIQ;
  end

  sync_fifo #(
    .Width ($bits(mem_instr_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_instr),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  // Ready comes from registered occupancy only: a full queue refuses input
  // even in a cycle where it also issues.
  assign ready_MIQ_OC = !rst && !full;
  assign push         = Instr_valid_OC_MIQ && ready_MIQ_OC;
  assign pop          = !rst && !empty && !stall_MEM_MIQ && (inflight != MaxInflight);
  // A completion with nothing in flight is dropped so the count cannot wrap.
  assign done_eff     = done_MEM_MIQ && (inflight != '0);

  // In-flight tracking: +1 per issue, -1 per completion, hold when both.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      unique case ({pop, done_eff})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign out_instr = pop ? head : '0;

  assign Instr_valid_MIQ_MEM       = pop;
  assign MemRead_MIQ_MEM           = out_instr.mem_read;
  assign MemWrite_MIQ_MEM          = out_instr.mem_write;
  assign shared_global_bar_MIQ_MEM = out_instr.shared_global_bar;
  assign PAM_MIQ_MEM               = out_instr.pam;
  assign warp_ID_MIQ_MEM           = out_instr.warp_id;
  assign scb_ID_MIQ_MEM            = out_instr.scb_id;
  assign rs_data_MIQ_MEM           = out_instr.rs_data;
  assign rt_data_MIQ_MEM           = out_instr.rt_data;
  assign offset_MIQ_MEM            = out_instr.offset;
  assign reg_addr_MIQ_MEM          = out_instr.reg_addr;

  assign count_MIQ = cnt;
  assign idle_MIQ  = (cnt == '0) && (inflight == '0);

endmodule
